ebs_dcache_miss_sampler: RTL and testbench
==========================================

# ebs_dcache_miss_sampler

Event-based sampling stage directly downstream of the write-through L1 data cache. Consumes the cache's per-miss pulse and the PC of the missing access, decimates misses by a programmable period, and buffers sampled PCs in a small FIFO for the CSR/trace readout path. Also keeps a free-running miss counter and a sticky overflow flag for lost samples.

## Interface
- XLEN, 64, width of sampled PC
- DEPTH, 4, sample FIFO entries (power of two, ≥2)
- CNT_WIDTH, 32, width of period, phase and miss counters
- IRQ_THRESH, 2, FIFO fill level (1..DEPTH) at which irq_o asserts
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  1  sampling/counting enable (from CSR)
- flush_i  in  1  clear FIFO, phase counter and overflow flag
- period_i  in  CNT_WIDTH  sample every period_i-th miss; 0 treated as 1
- miss_i  in  1  one-cycle miss pulse from data cache (at most one per cycle)
- miss_pc_i  in  XLEN  PC of the missing access, valid with miss_i
- sample_valid_o  out  1  FIFO head valid
- sample_pc_o  out  XLEN  FIFO head PC
- sample_ready_i  in  1  consumer pops head when sample_valid_o && sample_ready_i
- fill_o  out  $clog2(DEPTH)+1  current FIFO occupancy
- irq_o  out  1  fill_o ≥ IRQ_THRESH
- overflow_o  out  1  sticky: a sample was dropped because FIFO was full
- miss_count_o  out  CNT_WIDTH  total misses seen while enabled, wraps

## Operation
- Effective period P = (period_i == 0) ? 1 : period_i, read combinationally each cycle.
- Phase counter phase_q (CNT_WIDTH). Qualified miss m = miss_i && enable_i && !flush_i.
- On m: if phase_q + 1 ≥ P → sample event, phase_q ← 0; else phase_q ← phase_q + 1. Compare done at CNT_WIDTH+1 bits (no wrap on the +1).
- Lowering period_i below phase_q+1 makes the next qualified miss a sample; raising it just lengthens the current interval.
- On m: miss_count_o ← miss_count_o + 1 modulo 2^CNT_WIDTH.
- Sample event pushes miss_pc_i into FIFO tail. Push accepted if fill < DEPTH, or fill == DEPTH and a pop occurs the same cycle. Otherwise sample is dropped, overflow_o ← 1, FIFO unchanged.
- Pop: sample_valid_o && sample_ready_i; head advances. sample_pc_o is held stable while sample_valid_o && !sample_ready_i.
- FIFO: circular buffer, read/write pointers wrap at DEPTH, fill tracked as explicit counter; fill_o increments on push-only, decrements on pop-only, unchanged on push+pop.
- enable_i low: phase_q and miss_count_o hold; FIFO still drains; overflow_o holds.
- flush_i: FIFO emptied (pointers, fill → 0), phase_q → 0, overflow_o → 0; miss_count_o preserved; any miss and pop in the same cycle are ignored.
- Priority: rst_i > flush_i > push/pop.

## Timing
- Reset (rst_i high at clock edge): sample_valid_o=0, sample_pc_o=0, fill_o=0, irq_o=0, overflow_o=0, miss_count_o=0, phase_q=0, pointers=0.
- Miss-to-valid latency: 1 cycle (sample on edge N visible as sample_valid_o after edge N). No bypass from miss_i to sample outputs.
- Pop takes effect at the edge where sample_valid_o && sample_ready_i; next entry (if any) visible right after that edge.
- fill_o, irq_o, overflow_o, miss_count_o are registered/derived from registers; no combinational path from any input to any output except none (sample_pc_o driven from storage by read pointer).
- Sustained throughput: one push and one pop per cycle.
- Reset asserted mid-operation discards all buffered samples that cycle; no partial state survives.

## Test plan
- Period 3, enable=1, misses with PCs 0x100..0x105 on consecutive cycles, ready=0 → FIFO holds 0x102, 0x105; fill_o=2; irq_o=1; miss_count_o=6.
- period_i=0, DEPTH=4, 5 consecutive misses PC 0x10..0x14, ready=0 → FIFO holds 0x10..0x13, overflow_o=1 after 5th, fill_o=4.
- FIFO full, miss (period 1) and ready=1 same cycle → 0x10 popped, new PC pushed, fill_o stays 4, overflow_o unchanged.
- enable=0 with 10 misses → miss_count_o and phase unchanged, no pushes; re-enable, period 2, 2 misses → exactly one sample (second miss PC).
- Two samples buffered, overflow_o=1, assert flush_i with coincident miss → fill_o=0, sample_valid_o=0, overflow_o=0, miss_count_o not incremented by that miss.
- Assert rst_i with fill_o=3 and phase_q=1 → all outputs at reset values next cycle; period 2 then needs 2 new misses for first sample.

Source files
------------

// File: rtl/ebs_dcache_miss_sampler.sv
// ebs_dcache_miss_sampler: decimates D-cache miss pulses by a programmable period and queues sampled PCs
module ebs_dcache_miss_sampler #(
   parameter int XLEN       = 64,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 32,
   parameter int IRQ_THRESH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       enable_i,
   input  logic                       flush_i,
   input  logic [CNT_WIDTH-1:0]       period_i,
   input  logic                       miss_i,
   input  logic [XLEN-1:0]            miss_pc_i,
   output logic                       sample_valid_o,
   output logic [XLEN-1:0]            sample_pc_o,
   input  logic                       sample_ready_i,
   output logic [$clog2(DEPTH):0]     fill_o,
   output logic                       irq_o,
   output logic                       overflow_o,
   output logic [CNT_WIDTH-1:0]       miss_count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [XLEN-1:0]      r_mem [DEPTH];
   logic [AW-1:0]        r_wp, r_rp;
   logic [AW:0]          r_fill;
   logic [CNT_WIDTH-1:0] r_phase, r_cnt;
   logic                 r_ovf;
   logic [CNT_WIDTH-1:0] w_per;
   logic                 w_m, w_samp, w_pop, w_push;
   assign w_per  = (period_i == '0) ? CNT_WIDTH'(1) : period_i;
   assign w_m    = miss_i && enable_i && !flush_i;
   // one extra bit so phase+1 cannot wrap before the compare
   assign w_samp = w_m && (({1'b0, r_phase} + 1'b1) >= {1'b0, w_per});
   assign w_pop  = (r_fill != '0) && sample_ready_i && !flush_i;
   assign w_push = w_samp && ((r_fill != (AW+1)'(DEPTH)) || w_pop);
   assign sample_valid_o = (r_fill != '0);
   assign sample_pc_o    = r_mem[r_rp];
   assign fill_o         = r_fill;
   assign irq_o          = (r_fill >= (AW+1)'(IRQ_THRESH));
   assign overflow_o     = r_ovf;
   assign miss_count_o   = r_cnt;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wp    <= '0;
         r_rp    <= '0;
         r_fill  <= '0;
         r_phase <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else if (flush_i) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_fill  <= '0;
         r_phase <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_m) begin
            r_cnt   <= r_cnt + 1'b1;
            r_phase <= w_samp ? '0 : r_phase + 1'b1;
         end
         if (w_push) begin
            r_mem[r_wp] <= miss_pc_i;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_samp && !w_push) r_ovf <= 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_push && !w_pop) r_fill <= r_fill + 1'b1;
         else if (w_pop && !w_push) r_fill <= r_fill - 1'b1;
      end
   end
endmodule

// File: tb/tb_ebs_dcache_miss_sampler.sv
// tb_ebs_dcache_miss_sampler: directed stimulus with a PC scoreboard drained by an independent pop monitor
module tb_ebs_dcache_miss_sampler;
   logic        clk = 0, rst = 1, en = 0, flush = 0, miss = 0, ready = 0;
   logic [31:0] period = 0;
   logic [63:0] pc = 0;
   logic        valid, irq, ovf;
   logic [63:0] spc;
   logic [2:0]  fill;
   logic [31:0] cnt;
   int          n_cmp = 0, n_fail = 0;
   logic [63:0] sb [$];

   ebs_dcache_miss_sampler dut (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .flush_i(flush), .period_i(period),
      .miss_i(miss), .miss_pc_i(pc), .sample_valid_o(valid), .sample_pc_o(spc),
      .sample_ready_i(ready), .fill_o(fill), .irq_o(irq), .overflow_o(ovf),
      .miss_count_o(cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [63:0] p, input bit exp_push);
      miss = 1;
      pc = p;
      if (exp_push) sb.push_back(p);
      step();
      miss = 0;
   endtask

   task automatic drain(input int n);
      ready = 1;
      repeat (n) step();
      ready = 0;
   endtask

   always @(negedge clk)
      if (!rst && !flush && valid && ready) begin
         if (sb.size() == 0) chk("pop_unexpected", spc, 64'hx);
         else chk("pop_pc", spc, sb.pop_front());
      end

   initial begin
      repeat (2) step();
      rst = 0;
      chk("rst_valid", valid, 0);
      chk("rst_pc", spc, 0);
      chk("rst_fill", fill, 0);
      chk("rst_irq", irq, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_cnt", cnt, 0);
      // period 3: every third miss sampled
      en = 1;
      period = 3;
      for (int i = 0; i < 6; i++) do_miss(64'h100 + 64'(i), (i % 3) == 2);
      chk("p3_fill", fill, 2);
      chk("p3_irq", irq, 1);
      chk("p3_cnt", cnt, 6);
      chk("p3_ovf", ovf, 0);
      chk("p3_head", spc, 64'h102);
      drain(2);
      chk("p3_empty", fill, 0);
      chk("p3_irq_low", irq, 0);
      // period 0 behaves as 1; fifth sample dropped
      period = 0;
      for (int i = 0; i < 4; i++) do_miss(64'h10 + 64'(i), 1);
      chk("full_fill", fill, 4);
      chk("full_ovf_pre", ovf, 0);
      do_miss(64'h14, 0);
      chk("full_ovf", ovf, 1);
      chk("full_fill2", fill, 4);
      chk("full_head", spc, 64'h10);
      // push into full FIFO with a coincident pop
      ready = 1;
      do_miss(64'h20, 1);
      ready = 0;
      chk("pp_fill", fill, 4);
      chk("pp_ovf", ovf, 1);
      chk("pp_cnt", cnt, 12);
      chk("pp_head", spc, 64'h11);
      drain(4);
      chk("pp_empty", fill, 0);
      // disabled: no counting, no sampling
      period = 1;
      en = 0;
      for (int i = 0; i < 10; i++) do_miss(64'h30 + 64'(i), 0);
      chk("dis_cnt", cnt, 12);
      chk("dis_fill", fill, 0);
      en = 1;
      period = 2;
      do_miss(64'h40, 0);
      chk("reen_fill0", fill, 0);
      do_miss(64'h41, 1);
      chk("reen_fill1", fill, 1);
      chk("reen_cnt", cnt, 14);
      drain(1);
      // flush with coincident miss
      period = 1;
      do_miss(64'h50, 1);
      do_miss(64'h51, 1);
      chk("fl_pre_fill", fill, 2);
      chk("fl_pre_ovf", ovf, 1);
      flush = 1;
      sb.delete();
      do_miss(64'h52, 0);
      flush = 0;
      chk("fl_fill", fill, 0);
      chk("fl_valid", valid, 0);
      chk("fl_ovf", ovf, 0);
      chk("fl_cnt", cnt, 16);
      // reset mid-operation with fill 3, phase 1
      for (int i = 0; i < 3; i++) do_miss(64'h60 + 64'(i), 1);
      period = 2;
      do_miss(64'h63, 0);
      chk("mr_fill", fill, 3);
      rst = 1;
      sb.delete();
      step();
      rst = 0;
      chk("mr_valid", valid, 0);
      chk("mr_pc", spc, 0);
      chk("mr_fill0", fill, 0);
      chk("mr_irq", irq, 0);
      chk("mr_cnt", cnt, 0);
      do_miss(64'h70, 0);
      chk("mr_first", fill, 0);
      do_miss(64'h71, 1);
      chk("mr_second", fill, 1);
      chk("mr_cnt2", cnt, 2);
      chk("mr_head", spc, 64'h71);
      drain(1);
      step();
      chk("sb_left", 64'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
